// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared defaults and types for the sram_32x8 slice.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_DEPTH : geometry defaults (5 / 8 / 32)
//   addr_t / data_t                        : address and data word types
//   access_e                               : resolved bus access for a cycle
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 5;
    localparam int unsigned SRAM_DATA_W = 8;
    localparam int unsigned SRAM_DEPTH  = 2 ** SRAM_ADDR_W;

    typedef logic [SRAM_ADDR_W-1:0] addr_t;
    typedef logic [SRAM_DATA_W-1:0] data_t;

    // Outcome of strobe arbitration: reset forces IDLE, write beats read.
    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_e;

endpackage : sram_pkg

// File: rtl/sram_32x8_array.sv
// ---------------------------------------------------------------------------
// sram_32x8_array
// Storage array with a single synchronous write port, an asynchronous
// combinational read port and an asynchronous clear of every word.
// Ports:
//   clk      in   write clock (rising edge)
//   rst      in   async active-high clear of all words; blocks writes
//   i_we     in   write enable, sampled on clk
//   i_addr   in   word address shared by read and write
//   i_wdata  in   write data, stored unmodified (X/Z included)
//   o_rdata  out  mem[i_addr], combinational
// ---------------------------------------------------------------------------
module sram_32x8_array
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W,
    parameter int unsigned DEPTH  = SRAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : sram_32x8_array

// File: rtl/sram_32x8.sv
// ---------------------------------------------------------------------------
// sram_32x8
// 32 x 8 single-port SRAM on a shared bidirectional data bus.
// Ports:
//   clk    in     clock, all writes on the rising edge
//   rst    in     async active-high reset; clears memory, bus released
//   addr   in     word address for both read and write
//   data   inout  write data in / read data out (Z when not reading)
//   write  in     write strobe, level-sampled on clk
//   read   in     read strobe, combinational output enable
// The top only arbitrates the strobes and drives the tri-state bus; the
// storage lives in sram_32x8_array.
// ---------------------------------------------------------------------------
module sram_32x8
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W,
    parameter int unsigned DEPTH  = SRAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic              write,
    input  logic              read
);

    access_e           w_access;
    logic              w_we;
    logic              w_drive;
    logic [DATA_W-1:0] w_rdata;

    // Write wins over read so an external writer is never contended.
    always_comb begin
        w_access = ACC_IDLE;
        if (rst) begin
            w_access = ACC_IDLE;
        end else if (write) begin
            w_access = ACC_WRITE;
        end else if (read) begin
            w_access = ACC_READ;
        end
    end

    assign w_we    = (w_access == ACC_WRITE);
    assign w_drive = (w_access == ACC_READ);

    sram_32x8_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_addr  (addr),
        .i_wdata (data),
        .o_rdata (w_rdata)
    );

    // Sole driver of the bus inside the block.
    assign data = w_drive ? w_rdata : {DATA_W{1'bz}};

endmodule : sram_32x8

// File: tb/tb_sram_32x8.sv
module tb_sram_32x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       read;
    logic [4:0] addr;
    logic       tb_en;
    logic [7:0] tb_val;
    wire  [7:0] data_bus;

    // Bench side of the bus. When the DUT should be Z the bench drives a
    // known value; any DUT driver would corrupt what is observed.
    assign data_bus = tb_en ? tb_val : 8'bz;

    sram_32x8 #(
        .ADDR_W (5),
        .DATA_W (8),
        .DEPTH  (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .data  (data_bus),
        .write (write),
        .read  (read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t       q[$];
    event       sample_ev;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] ref_mem [32];

    // Monitor: pops one expectation per presented sample.
    initial begin
        chk_t c;
        forever begin
            @(sample_ev);
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample: data=%h with no expectation queued", data_bus);
            end else begin
                c = q.pop_front();
                if (data_bus !== c.exp) begin
                    fails++;
                    $display("FAIL %s: data=%h expected=%h (addr=%h)", c.name, data_bus, c.exp, addr);
                end
            end
        end
    end

    task automatic push_chk(input logic [7:0] e, input string n);
        chk_t c;
        c.exp  = e;
        c.name = n;
        q.push_back(c);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    endtask

    // One bus cycle: drive after the edge, sample mid-cycle, the write
    // (if any) lands on the following rising edge.
    task automatic cycle_op(input logic w, input logic r, input logic [4:0] a,
                            input logic [7:0] d, input string n);
        logic [7:0] e;
        @(posedge clk);
        #1;
        write = w;
        read  = r;
        addr  = a;
        if (w) begin
            tb_en  = 1'b1;
            tb_val = d;
            e      = d;
            ref_mem[a] = d;
        end else if (r) begin
            tb_en = 1'b0;
            e     = ref_mem[a];
        end else begin
            tb_en  = 1'b1;
            tb_val = 8'h00;
            e      = 8'h00;
        end
        push_chk(e, n);
        #2;
        ->sample_ev;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cycle_op(1'b1, 1'b0, a, d, "write_bus");
    endtask

    task automatic rd(input logic [4:0] a, input string n);
        cycle_op(1'b0, 1'b1, a, 8'h00, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        write  = 1'b0;
        read   = 1'b0;
        addr   = '0;
        tb_en  = 1'b1;
        tb_val = 8'h00;
        model_clear();
        #12;
        rst = 1'b0;

        // Reset state
        rd(5'h00, "reset_rd_00");
        rd(5'h1F, "reset_rd_1f");
        rd(5'h12, "reset_rd_12");

        // Basic write/read
        wr(5'h12, 8'h55);
        wr(5'h13, 8'hAA);
        rd(5'h12, "rd_12");
        rd(5'h13, "rd_13");

        // Combinational read: addr steps within one cycle, no edge between
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b1; tb_en = 1'b0; addr = 5'h12;
        push_chk(ref_mem[5'h12], "comb_rd_12");
        #1 ->sample_ev;
        #1 addr = 5'h13;
        push_chk(ref_mem[5'h13], "comb_rd_13");
        #1 ->sample_ev;

        // Idle and read=0 probes: DUT must release the bus
        cycle_op(1'b0, 1'b0, 5'h12, 8'h00, "idle_z");

        // Write and read together: write wins, bus not contended
        wr(5'h07, 8'hC3);
        cycle_op(1'b1, 1'b1, 5'h07, 8'h3C, "wr_rd_no_contention");
        rd(5'h07, "rd_07_after_wr_rd");

        // Held write strobe across three edges, then boundaries
        wr(5'h00, 8'h11);
        wr(5'h01, 8'h22);
        wr(5'h02, 8'h33);
        wr(5'h1F, 8'hE7);
        rd(5'h00, "burst_rd_00");
        rd(5'h01, "burst_rd_01");
        rd(5'h02, "burst_rd_02");
        rd(5'h1F, "boundary_rd_1f");

        // Asynchronous reset pulse entirely between clock edges
        wr(5'h1F, 8'h5A);
        wr(5'h00, 8'h99);
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0; tb_en = 1'b1; tb_val = 8'h00;
        rst = 1'b1;
        #2 rst = 1'b0;
        model_clear();
        rd(5'h1F, "async_rst_rd_1f");
        rd(5'h00, "async_rst_rd_00");
        rd(5'h12, "async_rst_rd_12");

        // Write held across an edge while in reset: aborted, bus released
        @(posedge clk);
        #1;
        rst = 1'b1; write = 1'b1; read = 1'b1; addr = 5'h1F;
        tb_en = 1'b1; tb_val = 8'hA5;
        push_chk(8'hA5, "rst_write_bus_z");
        #2 ->sample_ev;
        @(posedge clk);
        #1;
        rst = 1'b0; write = 1'b0; read = 1'b0; tb_val = 8'h00;
        model_clear();
        rd(5'h1F, "rst_write_aborted");
        wr(5'h1F, 8'h6B);
        rd(5'h1F, "post_rst_write");

        // Randomised traffic against the array model
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            logic [4:0]  a;
            logic [7:0]  d;
            op = $urandom_range(0, 3);
            a  = 5'($urandom_range(0, 31));
            d  = 8'($urandom_range(0, 255));
            case (op)
                0:       cycle_op(1'b1, 1'b0, a, d, "rand_write");
                1:       cycle_op(1'b0, 1'b1, a, d, "rand_read");
                2:       cycle_op(1'b0, 1'b0, a, d, "rand_idle_z");
                default: cycle_op(1'b1, 1'b1, a, d, "rand_wr_rd");
            endcase
        end

        // Sweep every address once so each word's final value is checked
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), "sweep_rd");
        end

        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0; tb_en = 1'b1; tb_val = 8'h00;
        @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sram_32x8
